imem_load_ctrl: RTL

Controller that owns the write side and read-address side of the byte-organized instruction memory. It loads a program image from a byte stream into the memory, holding the core stalled while it does so. After the load it shares the memory read address between core instruction fetch and a debug read port, using starvation-free arbitration. It sits between the boot/UART byte source, the instruction memory and the core fetch stage.

---
 rtl/imem_load_ctrl_if.sv | 31 +++
 rtl/imem_load_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl_if.sv
// Bus bundle between the instruction-memory load controller and its neighbours:
// boot byte stream, memory write port, core fetch and debug read requests.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic [ADDR_W-1:0] mem_addr;

  // Environment side: byte source, core and debugger
  modport master (
    output s_valid, s_data, fetch_req, fetch_addr, dbg_req, dbg_addr,
    input  s_ready, wr_en, wr_addr, wr_data, fetch_gnt, dbg_gnt, mem_addr
  );

  // Controller side
  modport slave (
    input  s_valid, s_data, fetch_req, fetch_addr, dbg_req, dbg_addr,
    output s_ready, wr_en, wr_addr, wr_data, fetch_gnt, dbg_gnt, mem_addr
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller: streams a program image into the byte
// memory while stalling the core, then arbitrates the read address between
// core fetch and debug reads with a starvation bound on debug.
module imem_load_ctrl #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start_i,
  input  logic [ADDR_W-1:0]   load_len_i,
  imem_load_ctrl_if.slave     bus,
  output logic                core_stall_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              s_ready;
  logic              fetch_gnt;
  logic              dbg_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              core_stall;

  assign cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state, load datapath and read-port arbitration
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    starve_d   = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    s_ready    = 1'b0;
    fetch_gnt  = 1'b0;
    dbg_gnt    = 1'b0;
    mem_addr   = '0;
    core_stall = 1'b1;

    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          len_d   = (load_len_i == '0) ? CNT_W'(DEPTH) : CNT_W'(load_len_i);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = bus.s_data;
          cnt_d     = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.fetch_req && (starve_q < STV_W'(STARVE_MAX))) begin
          fetch_gnt = 1'b1;
          mem_addr  = bus.fetch_addr;
          if (bus.fetch_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
        end else if (bus.dbg_req) begin
          dbg_gnt  = 1'b1;
          mem_addr = bus.dbg_addr;
        end
        // A denied fetch holds the PC; no request means nothing to hold
        core_stall = bus.fetch_req && !fetch_gnt;
        if (bus.dbg_req && !dbg_gnt) begin
          starve_d = (starve_q == STV_W'(STARVE_MAX)) ? starve_q
                                                      : STV_W'(starve_q + STV_W'(1));
        end
        // Reload wins over a same-cycle misaligned fetch when clearing err
        if (load_start_i) begin
          state_d = LOAD;
          len_d   = (load_len_i == '0) ? CNT_W'(DEPTH) : CNT_W'(load_len_i);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_ready   = s_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fetch_gnt = fetch_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.mem_addr  = mem_addr;
  assign core_stall_o  = core_stall;
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule
